// File: rtl/display_sram_write_arbiter.sv
// rtl/display_sram_write_arbiter.sv - two-way round-robin arbiter onto the framebuffer write port
// Registered grant: one request per cycle out, one-cycle ack back to the winner.
module display_sram_write_arbiter (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic        req0__valid,
  input  logic [3:0]  req0__id,
  input  logic        req0__read_not_write,
  input  logic [7:0]  req0__byte_enable,
  input  logic [31:0] req0__address,
  input  logic [63:0] req0__write_data,
  input  logic        req1__valid,
  input  logic [3:0]  req1__id,
  input  logic        req1__read_not_write,
  input  logic [7:0]  req1__byte_enable,
  input  logic [31:0] req1__address,
  input  logic [63:0] req1__write_data,
  output logic        ack0,
  output logic        ack1,
  output logic        display_sram_write__valid,
  output logic [3:0]  display_sram_write__id,
  output logic        display_sram_write__read_not_write,
  output logic [7:0]  display_sram_write__byte_enable,
  output logic [31:0] display_sram_write__address,
  output logic [63:0] display_sram_write__write_data
);

  logic        last_grant_q, last_grant_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        valid_q, valid_d;
  logic [3:0]  id_q, id_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic        elig0, elig1, grant0, grant1;

  // A requester whose ack is high is still holding the request just served.
  always_comb begin
    elig0  = req0__valid & ~ack0_q;
    elig1  = req1__valid & ~ack1_q;
    grant0 = elig0 & (~elig1 | last_grant_q);
    grant1 = elig1 & (~elig0 | ~last_grant_q);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    valid_d      = valid_q;
    id_d         = id_q;
    rnw_d        = rnw_q;
    be_d         = be_q;
    addr_d       = addr_q;
    data_d       = data_q;
    if (clk__enable) begin
      valid_d = grant0 | grant1;
      ack0_d  = grant0;
      ack1_d  = grant1;
      if (grant0) begin
        id_d         = req0__id;
        rnw_d        = req0__read_not_write;
        be_d         = req0__byte_enable;
        addr_d       = req0__address;
        data_d       = req0__write_data;
        last_grant_d = 1'b0;
      end else if (grant1) begin
        id_d         = req1__id;
        rnw_d        = req1__read_not_write;
        be_d         = req1__byte_enable;
        addr_d       = req1__address;
        data_d       = req1__write_data;
        last_grant_d = 1'b1;
      end
    end
  end

  // Reset favours req0 on the first contention by marking req1 as last served.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      rnw_q        <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      rnw_q        <= rnw_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign ack0                               = ack0_q;
  assign ack1                               = ack1_q;
  assign display_sram_write__valid          = valid_q;
  assign display_sram_write__id             = id_q;
  assign display_sram_write__read_not_write = rnw_q;
  assign display_sram_write__byte_enable    = be_q;
  assign display_sram_write__address        = addr_q;
  assign display_sram_write__write_data     = data_q;

endmodule

// File: tb/tb_display_sram_write_arbiter.sv
// tb/tb_display_sram_write_arbiter.sv - randomized and directed checks against a behavioural arbiter model
module tb_display_sram_write_arbiter;

  logic clk = 1'b0;
  logic clk__enable, reset;
  logic        r_valid [2];
  logic [3:0]  r_id    [2];
  logic        r_rnw   [2];
  logic [7:0]  r_be    [2];
  logic [31:0] r_addr  [2];
  logic [63:0] r_data  [2];

  logic        ack0, ack1, o_valid, o_rnw;
  logic [3:0]  o_id;
  logic [7:0]  o_be;
  logic [31:0] o_addr;
  logic [63:0] o_data;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // model state
  logic        m_valid = 0, m_rnw = 0, m_last = 1, m_edge_en = 0;
  logic        m_ack [2] = '{0, 0};
  logic [3:0]  m_id = 0;
  logic [7:0]  m_be = 0;
  logic [31:0] m_addr = 0;
  logic [63:0] m_data = 0;

  always #5 clk = ~clk;

  display_sram_write_arbiter dut (
    .clk(clk), .clk__enable(clk__enable), .reset(reset),
    .req0__valid(r_valid[0]), .req0__id(r_id[0]), .req0__read_not_write(r_rnw[0]),
    .req0__byte_enable(r_be[0]), .req0__address(r_addr[0]), .req0__write_data(r_data[0]),
    .req1__valid(r_valid[1]), .req1__id(r_id[1]), .req1__read_not_write(r_rnw[1]),
    .req1__byte_enable(r_be[1]), .req1__address(r_addr[1]), .req1__write_data(r_data[1]),
    .ack0(ack0), .ack1(ack1),
    .display_sram_write__valid(o_valid), .display_sram_write__id(o_id),
    .display_sram_write__read_not_write(o_rnw), .display_sram_write__byte_enable(o_be),
    .display_sram_write__address(o_addr), .display_sram_write__write_data(o_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Round-robin reference: who is eligible, who wins, what gets copied out.
  always @(posedge clk) begin
    bit e [2];
    int w;
    m_edge_en <= clk__enable && !reset;
    if (reset) begin
      m_valid <= 0; m_ack[0] <= 0; m_ack[1] <= 0; m_last <= 1;
      m_id <= 0; m_rnw <= 0; m_be <= 0; m_addr <= 0; m_data <= 0;
    end else if (clk__enable) begin
      for (int i = 0; i < 2; i++) e[i] = r_valid[i] && !m_ack[i];
      if (!e[0] && !e[1]) begin
        m_valid <= 0; m_ack[0] <= 0; m_ack[1] <= 0;
      end else begin
        if (e[0] && e[1]) w = m_last ? 0 : 1;
        else              w = e[1] ? 1 : 0;
        m_valid <= 1;
        m_ack[0] <= (w == 0);
        m_ack[1] <= (w == 1);
        m_last <= (w == 1);
        m_id <= r_id[w]; m_rnw <= r_rnw[w]; m_be <= r_be[w];
        m_addr <= r_addr[w]; m_data <= r_data[w];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack0", ack0, m_ack[0]);
      chk("ack1", ack1, m_ack[1]);
      chk("valid", o_valid, m_valid);
      chk("id", o_id, m_id);
      chk("rnw", o_rnw, m_rnw);
      chk("be", o_be, m_be);
      chk("addr", o_addr, m_addr);
      chk("data", o_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i, input logic [31:0] a, input logic [63:0] d);
    r_valid[i] = 1;
    r_id[i]    = 4'($urandom);
    r_rnw[i]   = 1'($urandom);
    r_be[i]    = 8'($urandom);
    r_addr[i]  = a;
    r_data[i]  = d;
  endtask

  initial begin
    int k;
    clk__enable = 1;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 0; r_id[i] = 0; r_rnw[i] = 0; r_be[i] = 0; r_addr[i] = 0; r_data[i] = 0;
    end
    new_req(0, 32'h100, 64'h41);
    new_req(1, 32'h200, 64'h42);

    // reset with both requesting
    tick();
    chk_on = 1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_ack0", ack0, 0);
      chk("rst_addr", o_addr, 0);
      if (c == 0) tick();
    end
    reset = 0;
    tick();
    chk("first_ack0", ack0, 1);
    chk("first_valid", o_valid, 1);
    chk("first_addr", o_addr, 32'h100);
    chk("first_data", o_data, 64'h41);
    r_valid[0] = 0;
    tick();
    chk("second_ack1", ack1, 1);
    chk("second_addr", o_addr, 32'h200);
    r_valid[1] = 0;
    tick();

    // dual contention
    new_req(0, 32'h1000, 64'h0);
    new_req(1, 32'h2000, 64'h0);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("dual_valid", o_valid, 1);
      chk("dual_ack0", ack0, (n % 2 == 0));
      chk("dual_addr", o_addr, (n % 2 == 0) ? 32'h1000 + n / 2 : 32'h2000 + n / 2);
      if (m_ack[0]) r_addr[0]++;
      if (m_ack[1]) r_addr[1]++;
    end
    r_valid[0] = 0; r_valid[1] = 0;
    tick();

    // single master streaming
    new_req(0, 32'h0, 64'h7);
    k = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("stream_valid", o_valid, (n % 2 == 0));
      if (o_valid) begin
        chk("stream_addr", o_addr, k);
        k++;
      end
      if (m_ack[0]) r_addr[0]++;
    end
    chk("stream_count", k, 3);
    r_valid[0] = 0;
    tick();

    // late arrival
    new_req(1, 32'h3000, 64'h1);
    tick();
    chk("late_ack1", ack1, 1);
    r_addr[1] = 32'h3001;
    new_req(0, 32'h4000, 64'h2);
    tick();
    chk("late_ack0", ack0, 1);
    chk("late_addr0", o_addr, 32'h4000);
    r_valid[0] = 0;
    tick();
    chk("late_ack1b", ack1, 1);
    chk("late_addr1", o_addr, 32'h3001);
    r_valid[1] = 0;
    tick();

    // enable stall
    new_req(0, 32'h5000, 64'h3);
    tick();
    chk("stall_pre", ack0, 1);
    clk__enable = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("stall_valid", o_valid, 1);
      chk("stall_ack0", ack0, 1);
      chk("stall_addr", o_addr, 32'h5000);
    end
    clk__enable = 1;
    tick();
    chk("stall_nodup_valid", o_valid, 0);
    chk("stall_nodup_ack0", ack0, 0);
    r_valid[0] = 0;
    tick();

    // reset mid-stream, with enable low to show reset priority
    new_req(1, 32'h6000, 64'h4);
    tick();
    chk("mid_ack1", ack1, 1);
    reset = 1;
    clk__enable = 0;
    new_req(0, 32'h7000, 64'h5);
    tick();
    chk("mid_rst_ack1", ack1, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_addr", o_addr, 0);
    reset = 0;
    clk__enable = 1;
    tick();
    chk("mid_after_ack0", ack0, 1);
    chk("mid_after_addr", o_addr, 32'h7000);
    r_valid[0] = 0;
    tick();
    chk("mid_after_ack1", ack1, 1);
    chk("mid_after_addr1", o_addr, 32'h6000);
    r_valid[1] = 0;
    tick();

    // randomized traffic obeying the requester contract
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      clk__enable = ($urandom_range(9) < 8);
      if (m_edge_en) begin
        for (int i = 0; i < 2; i++) begin
          if (r_valid[i] && m_ack[i]) begin
            if ($urandom_range(1) == 0) r_valid[i] = 0;
            else new_req(i, $urandom, {$urandom, $urandom});
          end else if (!r_valid[i] && $urandom_range(9) < 4) begin
            new_req(i, $urandom, {$urandom, $urandom});
          end
        end
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
